// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings and sequencer state shared by hilo_unit and the CPU control.
// Revision: 1.0
`default_nettype none

package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } hilo_state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register pair and multicycle sequencer around the external MDU.
// Revision: 1.0
`default_nettype none

module hilo_unit
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mt_hi,
  input  logic        mt_lo,
  input  logic [31:0] mt_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  output logic        mdu_mul_c,
  output logic        mdu_div_c,
  output logic        mdu_sign,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MUL_INIT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_INIT = CW'(DIV_LAT - 1);

  hilo_state_t   state, state_d;
  logic [1:0]    op_q;
  logic [CW-1:0] cnt;
  logic          last;
  logic          b_zero_div;

  assign last       = (cnt == '0);
  assign b_zero_div = op_is_div(op_q) && (mdu_b == 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    busy      = 1'b0;
    mdu_mul_c = 1'b0;
    mdu_div_c = 1'b0;
    mdu_sign  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy      = 1'b1;
        mdu_mul_c = ~op_q[1];
        mdu_div_c = op_q[1];
        mdu_sign  = ~op_q[0];
        if (last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      mdu_a    <= '0;
      mdu_b    <= '0;
      op_q     <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      if (state == ST_IDLE) begin
        // MT writes land first; a same-cycle start overwrites them at completion.
        if (mt_hi) hi <= mt_data;
        if (mt_lo) lo <= mt_data;
        if (start) begin
          mdu_a <= rs_data;
          mdu_b <= rt_data;
          op_q  <= op;
          cnt   <= op_is_div(op) ? DIV_INIT : MUL_INIT;
        end
      end else begin
        if (last) begin
          if (!b_zero_div) begin
            hi <= mdu_hi;
            lo <= mdu_lo;
          end
          done     <= 1'b1;
          div_zero <= b_zero_div;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: table-driven, hand-sequenced and randomized checks of hilo_unit with a behavioural MDU.
// Revision: 1.0
`default_nettype none

module tb_hilo_unit;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0, rt_data = '0;
  logic        mt_hi = 1'b0, mt_lo = 1'b0;
  logic [31:0] mt_data = '0;
  logic [31:0] hi, lo, mdu_a, mdu_b, mdu_hi, mdu_lo;
  logic        busy, done, div_zero, mdu_mul_c, mdu_div_c, mdu_sign;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hilo_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero),
    .mdu_a(mdu_a), .mdu_b(mdu_b),
    .mdu_mul_c(mdu_mul_c), .mdu_div_c(mdu_div_c), .mdu_sign(mdu_sign),
    .mdu_hi(mdu_hi), .mdu_lo(mdu_lo)
  );

  // Behavioural MDU; divide by zero returns junk so a wrongful write is visible.
  function automatic logic [63:0] mdu_model(input logic mul, input logic dv, input logic sg,
                                            input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    sa = sg ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sg ? longint'($signed(b)) : longint'({32'b0, b});
    if (mul) begin
      p = sa * sb;
      return p;
    end else if (dv) begin
      if (b == 32'd0) return 64'hDEADBEEF_BADC0FFE;
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return 64'h0;
  endfunction

  assign {mdu_hi, mdu_lo} = mdu_model(mdu_mul_c, mdu_div_c, mdu_sign, mdu_a, mdu_b);

  // Reference: architectural HI/LO after an op, from the ISA rules.
  function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] old);
    longint x, y, p;
    bit s;
    s = (o == 2'b00) || (o == 2'b10);
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    if (o < 2'b10) begin
      p = x * y;
      return {1'b0, p[63:0]};
    end
    if (b == 0) return {1'b1, old};
    p = x - (x / y) * y;
    return {1'b0, p[31:0], 32'(x / y)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op from IDLE and check latency, busy width, controls and result.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz);
    int n, busy_cnt, lat;
    lat = o[1] ? DIV_LAT : MUL_LAT;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0; op = ~o; rs_data = ~a; rt_data = ~b;
    n = 0; busy_cnt = 0;
    check({name, " ctrl"}, {61'b0, mdu_mul_c, mdu_div_c, mdu_sign}, {61'b0, ~o[1], o[1], ~o[0]});
    check({name, " operands"}, {mdu_a, mdu_b}, {a, b});
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(lat));
    check({name, " busy_cycles"}, 64'(busy_cnt), 64'(lat));
    check({name, " result"}, {hi, lo}, {ehi, elo});
    check({name, " div_zero/busy"}, {62'b0, div_zero, busy}, {62'b0, edz, 1'b0});
  endtask

  task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
    @(negedge clk);
    mt_hi = h; mt_lo = l; mt_data = d;
    @(negedge clk);
    mt_hi = 1'b0; mt_lo = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  o;
    logic [31:0] a, b, ehi, elo;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [64:0] r;
    int n;
    bit seen;

    vecs[0] = '{"mult_neg",  2'b00, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1] = '{"multu",     2'b01, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{"div_7_m2",  2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[3] = '{"divu_7_2",  2'b11, 32'd7, 32'd2, 32'h00000001, 32'h00000003};
    vecs[4] = '{"div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
    vecs[5] = '{"multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};

    #1;
    check("reset outputs", {hi, lo}, 64'h0);
    check("reset flags", {58'b0, busy, done, div_zero, mdu_mul_c, mdu_div_c, mdu_sign}, 64'h0);
    check("reset operands", {mdu_a, mdu_b}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, 1'b0);

    // Divide by zero keeps preloaded HI/LO.
    mt_write(1'b1, 1'b0, 32'h11111111);
    mt_write(1'b0, 1'b1, 32'h22222222);
    check("mt preload", {hi, lo}, 64'h11111111_22222222);
    run_op("div_zero", 2'b10, 32'd5, 32'd0, 32'h11111111, 32'h22222222, 1'b1);
    run_op("divu_zero", 2'b11, 32'd5, 32'd0, 32'h11111111, 32'h22222222, 1'b1);

    // start and MT during RUN are ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b11; rs_data = 32'd100; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs_data = 32'd3; rt_data = 32'd3;
    mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'h0000ABCD;
    @(negedge clk);
    start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
    check("run ignores mt/start", {hi, lo, mdu_a}, {32'h11111111, 32'h22222222, 32'd100});
    n = 1;
    while (!done && n < 40) begin @(negedge clk); n++; end
    check("run ignore latency", 64'(n), 64'(DIV_LAT));
    check("run ignore result", {hi, lo}, {32'd2, 32'd14});
    @(negedge clk);
    check("no queued op", {62'b0, busy, done}, 64'h0);

    mt_write(1'b1, 1'b1, 32'h0000ABCD);
    check("mt both idle", {hi, lo}, 64'h0000ABCD_0000ABCD);

    // MT together with start: MT visible first, op result later.
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_data = 32'd6; rt_data = 32'd7;
    mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 32'h55AA55AA;
    @(negedge clk);
    start = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0;
    check("mt with start", {hi, lo, 63'b0, busy}, {32'h55AA55AA, 32'h55AA55AA, 64'h1});
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    check("mt+start result", {hi, lo}, {32'd0, 32'd42});

    // Reset at cycle 4 of a DIV aborts it.
    @(negedge clk);
    start = 1'b1; op = 2'b10; rs_data = 32'd77; rt_data = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async reset", {hi, lo, 63'b0, busy}, 64'h0);
    check("async reset ctrl", {61'b0, mdu_mul_c, mdu_div_c, mdu_sign}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check("no done after reset", {63'b0, seen}, 64'h0);

    // Randomized ops against the reference model.
    for (int k = 0; k < 24; k++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'(int'($urandom_range(0, 4)) - 2);
      r = ref_op(ro, ra, rb, {hi, lo});
      run_op($sformatf("rand%0d", k), ro, ra, rb, r[63:32], r[31:0], r[64]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
